// File: rtl/dw03_bictr_sweep_ctl_if.sv
// Bundle between the sweep sequencer, its host and the 4-bit up/down counter.
// Latency: none. The interface holds wires only.
// Backpressure: none. The counter follows load and cen on every clock.
interface dw03_bictr_sweep_ctl_if #(
    parameter int PRE_W = 8,
    parameter int REP_W = 4
);
    // host command / configuration
    logic             start;
    logic             abort;
    logic [3:0]       cfg_start;
    logic [3:0]       cfg_end;
    logic             cfg_dir;
    logic             cfg_bounce;
    logic [PRE_W-1:0] cfg_prescale;
    logic [REP_W-1:0] cfg_repeat;
    // counter feedback
    logic             tercnt;
    logic [3:0]       count;
    // counter control
    logic [3:0]       data;
    logic             load;
    logic             up_dn;
    logic             cen;
    logic [3:0]       count_to;
    // status
    logic             busy;
    logic             done;
    logic [REP_W-1:0] pass_cnt;

    // The sweep controller
    modport slave (
        input  start, abort, cfg_start, cfg_end, cfg_dir, cfg_bounce,
               cfg_prescale, cfg_repeat, tercnt, count,
        output data, load, up_dn, cen, count_to, busy, done, pass_cnt
    );

    // Host plus counter environment
    modport master (
        output start, abort, cfg_start, cfg_end, cfg_dir, cfg_bounce,
               cfg_prescale, cfg_repeat, tercnt, count,
        input  data, load, up_dn, cen, count_to, busy, done, pass_cnt
    );
endinterface

// File: rtl/dw03_bictr_sweep_ctl.sv
// Sweep sequencer: drives a 4-bit up/down counter through start->end passes at a prescaled step rate.
// Latency: start -> load 1 cycle -> first cen 2 cycles; a pass with prescale 0 takes distance+3 cycles.
// Backpressure: none. start is taken only in IDLE, and abort returns to IDLE on the next edge.
module dw03_bictr_sweep_ctl #(
    parameter int PRE_W = 8,
    parameter int REP_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    dw03_bictr_sweep_ctl_if.slave   io_bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_TURN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // configuration shadow, frozen for the whole sequence
    logic [3:0]       r_sh_start;
    logic [3:0]       r_sh_end;
    logic             r_sh_bounce;
    logic [PRE_W-1:0] r_sh_prescale;
    logic [REP_W-1:0] r_sh_repeat;

    // datapath
    logic [PRE_W-1:0] r_presc;
    logic [REP_W:0]   r_pass;      // one extra bit so that repeat = all-ones can reach its target
    logic [3:0]       r_data;
    logic             r_up_dn;
    logic [3:0]       r_count_to;

    logic             w_tick;
    logic [REP_W:0]   w_pass_nxt;
    logic [REP_W:0]   w_pass_tgt;
    logic             w_last;
    logic             w_load;
    logic             w_cen;
    logic             w_busy;
    logic             w_done;

    assign w_tick     = (r_presc == r_sh_prescale);
    assign w_pass_nxt = r_pass + {{REP_W{1'b0}}, 1'b1};
    assign w_pass_tgt = {1'b0, r_sh_repeat} + {{REP_W{1'b0}}, 1'b1};
    assign w_last     = (w_pass_nxt == w_pass_tgt);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle strobes. cen is combinational from tercnt, so the terminal count always blocks a step.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cen       = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (io_bus.start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (io_bus.tercnt) begin
                    w_state_nxt = S_TURN;
                end else begin
                    w_cen = w_tick;
                end
            end
            S_TURN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (r_sh_bounce) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                w_done      = ~io_bus.abort;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // abort overrides any sequencing decision
        if (io_bus.abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Shadow capture, prescaler, pass counter and counter-control registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh_start    <= 4'd0;
            r_sh_end      <= 4'd0;
            r_sh_bounce   <= 1'b0;
            r_sh_prescale <= '0;
            r_sh_repeat   <= '0;
            r_presc       <= '0;
            r_pass        <= '0;
            r_data        <= 4'd0;
            r_up_dn       <= 1'b1;
            r_count_to    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_sh_start    <= io_bus.cfg_start;
                        r_sh_end      <= io_bus.cfg_end;
                        r_sh_bounce   <= io_bus.cfg_bounce;
                        r_sh_prescale <= io_bus.cfg_prescale;
                        r_sh_repeat   <= io_bus.cfg_repeat;
                        r_pass        <= '0;
                        r_data        <= io_bus.cfg_start;
                        r_up_dn       <= io_bus.cfg_dir;
                        r_count_to    <= io_bus.cfg_end;
                    end
                end
                S_LOAD: begin
                    r_presc <= '0;
                end
                S_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + {{(PRE_W-1){1'b0}}, 1'b1};
                end
                S_TURN: begin
                    // an aborted turn does not count as a completed pass
                    if (!io_bus.abort) begin
                        r_pass <= w_pass_nxt;
                        if (!w_last && r_sh_bounce) begin
                            // reverse in place; the counter keeps its position
                            r_up_dn    <= ~r_up_dn;
                            r_count_to <= (r_count_to == r_sh_end) ? r_sh_start : r_sh_end;
                            r_presc    <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.data     = r_data;
    assign io_bus.load     = w_load;
    assign io_bus.up_dn    = r_up_dn;
    assign io_bus.cen      = w_cen;
    assign io_bus.count_to = r_count_to;
    assign io_bus.busy     = w_busy;
    assign io_bus.done     = w_done;
    // the visible count saturates at all-ones once the wide internal count passes it
    assign io_bus.pass_cnt = r_pass[REP_W] ? {REP_W{1'b1}} : r_pass[REP_W-1:0];

endmodule
